// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between a CPU port and a debug port
module dmem_arbiter #(
    parameter int AW       = 6,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cpu_req,
    input  logic          i_cpu_wr,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_gnt,
    output logic          o_cpu_rvalid,
    output logic [DW-1:0] o_cpu_rdata,
    input  logic          i_cpu_rready,
    input  logic          i_dbg_req,
    input  logic          i_dbg_wr,
    input  logic [AW-1:0] i_dbg_addr,
    input  logic [DW-1:0] i_dbg_wdata,
    output logic          o_dbg_gnt,
    output logic          o_dbg_rvalid,
    output logic [DW-1:0] o_dbg_rdata,
    input  logic          i_dbg_rready,
    output logic          o_mem_wr,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_din,
    input  logic [DW-1:0] i_mem_dout
);
    typedef enum logic {S_IDLE, S_RESP} state_t;
    state_t        r_state, w_state_nxt;
    logic          r_owner;
    logic [3:0]    r_wait_cnt;
    logic          r_cpu_rvalid, r_dbg_rvalid;
    logic [DW-1:0] r_cpu_rdata, r_dbg_rdata;
    logic          w_can_accept, w_dbg_first, w_cpu_gnt, w_dbg_gnt;

    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_dbg_gnt    = w_dbg_gnt;
    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_dbg_rvalid = r_dbg_rvalid;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_dbg_rdata  = r_dbg_rdata;

    // State register: IDLE or holding a response for the current owner
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Arbitrate (debug first once starved), steer the memory, pick next state
    always_comb begin
        w_can_accept = i_rst_n && (r_state == S_IDLE || (r_owner ? i_dbg_rready : i_cpu_rready));
        w_dbg_first  = r_wait_cnt >= 4'(MAX_WAIT) || !i_cpu_req;
        w_dbg_gnt    = w_can_accept && i_dbg_req && w_dbg_first;
        w_cpu_gnt    = w_can_accept && i_cpu_req && !w_dbg_gnt;
        o_mem_wr     = (w_dbg_gnt && i_dbg_wr) || (w_cpu_gnt && i_cpu_wr);
        o_mem_addr   = w_dbg_gnt ? i_dbg_addr  : w_cpu_gnt ? i_cpu_addr  : '0;
        o_mem_din    = w_dbg_gnt ? i_dbg_wdata : w_cpu_gnt ? i_cpu_wdata : '0;
        w_state_nxt  = (w_cpu_gnt || w_dbg_gnt) ? S_RESP : w_can_accept ? S_IDLE : r_state;
    end

    // Capture responses on grant; hold them until the port consumes them
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner      <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            if (w_cpu_gnt || w_dbg_gnt) r_owner <= w_dbg_gnt;
            r_cpu_rvalid <= w_cpu_gnt || (r_cpu_rvalid && !i_cpu_rready);
            r_dbg_rvalid <= w_dbg_gnt || (r_dbg_rvalid && !i_dbg_rready);
            if (w_cpu_gnt) r_cpu_rdata <= i_cpu_wr ? '0 : i_mem_dout;
            if (w_dbg_gnt) r_dbg_rdata <= i_dbg_wr ? '0 : i_mem_dout;
        end
    end

    // Count cycles the debug port has been kept waiting, saturating at MAX_WAIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                     r_wait_cnt <= '0;
        else if (!i_dbg_req || w_dbg_gnt) r_wait_cnt <= '0;
        else if (r_wait_cnt < 4'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + 4'd1;
    end
endmodule
